// File: rtl/vga_fb_fill.sv
// Rectangle fill engine for a 256x192x8 framebuffer: a small register bus
// configures origin/size/colour and one pixel is written per cycle on port A.
module vga_fb_fill (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  output logic [31:0] rdata,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        busy,
  output logic        dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  // Bus handshake: valid alone qualifies a transfer; there is no ready, every
  // valid cycle is accepted, and read data appears on rdata one cycle later.
  state_t      state_q;
  logic [7:0]  x0_q, y0_q, wm1_q, hm1_q, color_q;
  logic [7:0]  x_q, y_q, xe_q, ye_q;
  logic [15:0] count_q;
  logic        ovr_q, clip_q;
  logic [31:0] rdata_q;
  logic        fb_we_q;
  logic [15:0] fb_addr_q;
  logic [7:0]  fb_wdata_q;

  logic        wr, rd, cmd_wr, start_req, abort_req;
  logic [8:0]  xsum, ysum;
  logic [7:0]  xe_d, ye_d, x_d, y_d;
  logic        clamp_d, y0_ok, last_px;
  logic [31:0] rdata_d;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  always_comb begin
    wr        = valid & wstrb;
    rd        = valid & ~wstrb;
    cmd_wr    = wr && (addr == 3'd3);
    abort_req = cmd_wr && wdata[1];
    start_req = cmd_wr && wdata[0] && !wdata[1];
    // 9-bit sums so a rectangle running off the right/bottom edge clamps, never wraps
    xsum      = {1'b0, x0_q} + {1'b0, wm1_q};
    ysum      = {1'b0, y0_q} + {1'b0, hm1_q};
    xe_d      = xsum[8] ? 8'd255 : xsum[7:0];
    ye_d      = (ysum > 9'd191) ? 8'd191 : ysum[7:0];
    clamp_d   = xsum[8] || (ysum > 9'd191);
    y0_ok     = (y0_q < 8'd192);
    last_px   = (x_q == xe_q) && (y_q == ye_q);
    x_d       = (x_q == xe_q) ? x0_q : x_q + 8'd1;
    y_d       = (x_q == xe_q) ? y_q + 8'd1 : y_q;
    rdata_d   = 32'd0;
    case (addr)
      3'd0:    rdata_d = {16'd0, y0_q, x0_q};
      3'd1:    rdata_d = {16'd0, hm1_q, wm1_q};
      3'd2:    rdata_d = {24'd0, color_q};
      3'd4:    rdata_d = {29'd0, clip_q, ovr_q, (state_q == S_FILL)};
      3'd5:    rdata_d = {16'd0, count_q};
      default: rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      x0_q       <= 8'd0;
      y0_q       <= 8'd0;
      wm1_q      <= 8'd0;
      hm1_q      <= 8'd0;
      color_q    <= 8'd0;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      xe_q       <= 8'd0;
      ye_q       <= 8'd0;
      count_q    <= 16'd0;
      ovr_q      <= 1'b0;
      clip_q     <= 1'b0;
      rdata_q    <= 32'd0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= 16'd0;
      fb_wdata_q <= 8'd0;
    end else begin
      if (rd) rdata_q <= rdata_d;
      if (wr && state_q == S_IDLE) begin
        case (addr)
          3'd0:    begin x0_q  <= wdata[7:0]; y0_q  <= wdata[15:8]; end
          3'd1:    begin wm1_q <= wdata[7:0]; hm1_q <= wdata[15:8]; end
          3'd2:    color_q <= wdata[7:0];
          default: ;
        endcase
      end
      // Clears are issued first so a set event later in this block wins
      if (wr && addr == 3'd4) begin
        if (wdata[1]) ovr_q  <= 1'b0;
        if (wdata[2]) clip_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            count_q <= 16'd0;
            if (!y0_ok) begin
              clip_q <= 1'b1;
            end else begin
              state_q    <= S_FILL;
              x_q        <= x0_q;
              y_q        <= y0_q;
              xe_q       <= xe_d;
              ye_q       <= ye_d;
              if (clamp_d) clip_q <= 1'b1;
              fb_we_q    <= 1'b1;
              fb_addr_q  <= {y0_q, x0_q};
              fb_wdata_q <= color_q;
            end
          end
        end
        S_FILL: begin
          count_q <= count_q + 16'd1;
          if (start_req) ovr_q <= 1'b1;
          if (abort_req || last_px) begin
            state_q <= S_IDLE;
            fb_we_q <= 1'b0;
          end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            fb_addr_q <= {y_d, x_d};
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_wdata    = fb_wdata_q;
  assign busy        = (state_q == S_FILL);
  assign dbg_state_o = (state_q == S_FILL);

endmodule

// File: tb/tb_vga_fb_fill.sv
// Bench for vga_fb_fill: directed and random rectangle fills compared against
// a raster-order pixel list built from the rectangle geometry.
module tb_vga_fb_fill;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic        wstrb = 1'b0;
  logic [31:0] rdata;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        busy;
  logic        dbg_state;

  vga_fb_fill dut (
    .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic [15:0] got_addr_q[$];
  logic [7:0]  got_data_q[$];
  logic [15:0] exp_q[$];

  // monitor: capture every framebuffer write away from the active edge
  always @(negedge clk) begin
    if (fb_we) begin
      got_addr_q.push_back(fb_addr);
      got_data_q.push_back(fb_wdata);
    end
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers: called on a negedge, return on the following negedge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    valid = 1'b1; addr = a; wdata = d; wstrb = 1'b1;
    @(negedge clk);
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    valid = 1'b1; addr = a; wstrb = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    d = rdata;
  endtask

  // reference model: the clipped rectangle's pixels in raster order
  task automatic build_model(input int x0, input int y0, input int wm1, input int hm1,
                             output int n, output logic clip);
    int xe, ye;
    exp_q.delete();
    n = 0;
    clip = 1'b1;
    if (y0 < 192) begin
      xe = (x0 + wm1 > 255) ? 255 : x0 + wm1;
      ye = (y0 + hm1 > 191) ? 191 : y0 + hm1;
      clip = (x0 + wm1 > 255) || (y0 + hm1 > 191);
      for (int y = y0; y <= ye; y++)
        for (int x = x0; x <= xe; x++)
          exp_q.push_back(16'(y * 256 + x));
      n = exp_q.size();
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] color);
    int am = 0;
    int dm = 0;
    check({tag, "_nwrites"}, got_addr_q.size(), exp_q.size());
    for (int i = 0; i < got_addr_q.size() && i < exp_q.size(); i++) begin
      if (got_addr_q[i] !== exp_q[i]) am++;
      if (got_data_q[i] !== color) dm++;
    end
    check({tag, "_addr_mism"}, am, 0);
    check({tag, "_data_mism"}, dm, 0);
  endtask

  task automatic run_fill(input string tag, input int x0, input int y0, input int wm1,
                          input int hm1, input logic [7:0] color);
    int n;
    logic clip;
    logic [31:0] rd;
    bus_write(3'd4, 32'h6);
    bus_write(3'd0, 32'((y0 << 8) | x0));
    bus_write(3'd1, 32'((hm1 << 8) | wm1));
    bus_write(3'd2, {24'd0, color});
    build_model(x0, y0, wm1, hm1, n, clip);
    got_addr_q.delete(); got_data_q.delete(); busy_cnt = 0;
    bus_write(3'd3, 32'h1);
    wait_idle(60000);
    check_writes(tag, color);
    check({tag, "_busy_cycles"}, busy_cnt, n);
    bus_read(3'd4, rd);
    check({tag, "_status"}, rd, {29'd0, clip, 2'b00});
    bus_read(3'd5, rd);
    check({tag, "_count"}, rd, n);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    logic clip;

    repeat (3) @(negedge clk);
    check("rst_fb_we", {31'd0, fb_we}, 0);
    check("rst_fb_addr", {16'd0, fb_addr}, 0);
    check("rst_fb_wdata", {24'd0, fb_wdata}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rdata", rdata, 0);
    resetn = 1'b1;
    @(negedge clk);
    bus_read(3'd4, rd); check("rst_status", rd, 0);
    bus_read(3'd5, rd); check("rst_count", rd, 0);
    bus_read(3'd0, rd); check("rst_origin", rd, 0);

    // 2x2 square, then register readback
    run_fill("sq2x2", 8'h0A, 8'h05, 1, 1, 8'hAA);
    bus_read(3'd0, rd); check("rb_origin", rd, 32'h050A);
    bus_read(3'd1, rd); check("rb_size", rd, 32'h0101);
    bus_read(3'd2, rd); check("rb_color", rd, 32'hAA);
    bus_read(3'd3, rd); check("rb_cmd", rd, 0);
    bus_read(3'd6, rd); check("rb_idx6", rd, 0);

    // right-edge clamp, no wrap
    run_fill("xclip", 8'hFA, 8'h00, 8'h0F, 0, 8'h3C);
    // origin below the screen: nothing written
    run_fill("yoff", 8'h00, 8'hC8, 3, 3, 8'h11);

    // random rectangles, some running off the edges
    for (int t = 0; t < 8; t++) begin
      run_fill($sformatf("rnd%0d", t), $urandom_range(0, 255), $urandom_range(0, 199),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12),
               $urandom_range(0, 7), 8'($urandom_range(0, 255)));
    end

    // full screen with a mid-fill start and colour write
    bus_write(3'd4, 32'h6);
    bus_write(3'd0, 32'h0000);
    bus_write(3'd1, 32'hBFFF);
    bus_write(3'd2, 32'h33);
    build_model(0, 0, 255, 191, n, clip);
    got_addr_q.delete(); got_data_q.delete(); busy_cnt = 0;
    bus_write(3'd3, 32'h1);
    repeat (97) @(negedge clk);
    bus_write(3'd3, 32'h1);
    bus_write(3'd2, 32'h77);
    wait_idle(60000);
    check_writes("full", 8'h33);
    check("full_busy_cycles", busy_cnt, 49152);
    check("full_last_addr", (got_addr_q.size() > 0) ? {16'd0, got_addr_q[$]} : 32'hFFFF_FFFF, 32'hBFFF);
    bus_read(3'd4, rd); check("full_status_ovr", rd, 32'h2);
    bus_read(3'd5, rd); check("full_count", rd, 49152);
    bus_read(3'd2, rd); check("full_color_kept", rd, 32'h33);
    bus_write(3'd4, 32'h2);
    bus_read(3'd4, rd); check("ovr_cleared", rd, 0);

    // abort after ten writes of an 8x8 square
    bus_write(3'd0, 32'h1020);
    bus_write(3'd1, 32'h0707);
    bus_write(3'd2, 32'h5C);
    build_model(8'h20, 8'h10, 7, 7, n, clip);
    while (exp_q.size() > 10) void'(exp_q.pop_back());
    got_addr_q.delete(); got_data_q.delete();
    bus_write(3'd3, 32'h1);
    repeat (9) @(negedge clk);
    bus_write(3'd3, 32'h3);
    check("abort_fb_we", {31'd0, fb_we}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    repeat (4) @(negedge clk);
    check_writes("abort", 8'h5C);
    bus_read(3'd5, rd); check("abort_count", rd, 10);
    bus_read(3'd4, rd); check("abort_status", rd, 0);
    bus_write(3'd3, 32'h2);
    check("idle_abort_busy", {31'd0, busy}, 0);
    bus_read(3'd5, rd); check("idle_abort_count", rd, 10);
    run_fill("after_abort", $urandom_range(0, 250), $urandom_range(0, 180), 4, 3, 8'h9E);

    // reset pulse during a fill
    bus_write(3'd0, 32'h0804);
    bus_write(3'd1, 32'h0707);
    bus_write(3'd2, 32'hE1);
    got_addr_q.delete(); got_data_q.delete();
    bus_write(3'd3, 32'h1);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mrst_fb_we", {31'd0, fb_we}, 0);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_fb_addr", {16'd0, fb_addr}, 0);
    check("mrst_fb_wdata", {24'd0, fb_wdata}, 0);
    check("mrst_rdata", rdata, 0);
    repeat (20) @(negedge clk);
    check("mrst_nwrites", got_addr_q.size(), 6);
    bus_read(3'd4, rd); check("mrst_status", rd, 0);
    bus_read(3'd5, rd); check("mrst_count", rd, 0);
    bus_read(3'd2, rd); check("mrst_color", rd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_fill.md
VGA_FB_FILL -- requirements
Module: vga_fb_fill

Interface
REQ-001: clk  input  1  single system clock; all logic on rising edge.
REQ-002: resetn  input  1  synchronous reset, active-low, sampled on rising edge of clk.
REQ-003: valid  input  1  bus select for this block, qualified per cycle.
REQ-004: addr  input  3  register word index.
REQ-005: wdata  input  32  bus write data.
REQ-006: wstrb  input  1  1 = write, 0 = read.
REQ-007: rdata  output  32  registered read data, valid the cycle after the read request.
REQ-008: fb_we  output  1  framebuffer port-A write enable, registered.
REQ-009: fb_addr  output  16  framebuffer port-A address {y[7:0], x[7:0]}, registered.
REQ-010: fb_wdata  output  8  framebuffer port-A pixel, registered.
REQ-011: busy  output  1  high while a fill is in progress.

Function
REQ-012: Framebuffer geometry SHALL be 256 x 192 pixels, 8 bits per pixel, address = y*256 + x; the block is the sole driver of port A.
REQ-013: Register map, writes: 0 ORIGIN (x0=wdata[7:0], y0=wdata[15:8]); 1 SIZE (wm1=wdata[7:0] = width-1, hm1=wdata[15:8] = height-1); 2 COLOR (wdata[7:0]); 3 CMD (bit0 = start, bit1 = abort); 4 STATUS (writing bit1=1 clears OVR, writing bit2=1 clears CLIP).
REQ-014: Register map, reads: 4 STATUS {29'd0, CLIP, OVR, busy}; 5 COUNT {16'd0, pixels written by the last or current fill}; 0-2 read back the stored fields zero-extended; any other index reads 0.
REQ-015: Writes to ORIGIN, SIZE and COLOR while busy=1 SHALL be ignored.
REQ-016: The FSM SHALL have states IDLE and FILL.
REQ-017: IDLE->FILL SHALL occur on the edge that samples a start write (valid, addr=3, wstrb, wdata[0]=1, wdata[1]=0) with y0 <= 191; on that edge x, y and COUNT are loaded with x0, y0 and 0.
REQ-018: A start whose y0 >= 192 SHALL stay in IDLE, perform no writes, set CLIP and load COUNT with 0.
REQ-019: Effective column end SHALL be xe = min(x0 + wm1, 255) and effective row end ye = min(y0 + hm1, 191), computed with 9-bit arithmetic (no wrap); if either is clamped, CLIP is set at start.
REQ-020: In FILL the block SHALL present one pixel per cycle, fb_we=1, in raster order: x from x0 to xe, then x back to x0 and y+1, until (xe, ye).
REQ-021: The first fb_we SHALL be high in the cycle after the start edge; COUNT increments on every fb_we cycle.
REQ-022: After the write of (xe, ye) the FSM SHALL return to IDLE; fb_we and busy are 0 in the following cycle; busy is high for exactly (xe-x0+1)*(ye-y0+1) cycles.
REQ-023: busy SHALL equal (state == FILL).
REQ-024: A start write while busy=1 SHALL be ignored and set OVR (sticky).
REQ-025: An abort write (addr 3, wdata[1]=1) SHALL force IDLE on that edge, with fb_we=0 from the next cycle and COUNT frozen; if bit0 and bit1 are both set, abort wins.
REQ-026: Abort while IDLE SHALL have no effect.
REQ-027: A same-cycle STATUS clear and a set event SHALL leave the flag set.
REQ-028: fb_wdata SHALL hold COLOR as latched at start for the whole fill.

Reset
REQ-029: With resetn=0 at an edge: state=IDLE, busy=0, fb_we=0, fb_addr=0, fb_wdata=0, rdata=0, and all registers, COUNT, OVR and CLIP = 0.
REQ-030: Reset during FILL SHALL stop writes from the next cycle; no fill resumes after release.

Verification
REQ-031: ORIGIN=0x050A, SIZE=0x0101, COLOR=0xAA, start -> fb_we for 4 cycles at addresses 0x050A, 0x050B, 0x060A, 0x060B with data 0xAA; busy for 4 cycles; COUNT=4; CLIP=0.
REQ-032: ORIGIN=0x00FA, SIZE=0x000F, start -> 6 writes at 0x00FA-0x00FF, no wrap to x=0; CLIP=1.
REQ-033: ORIGIN=0xC800 (y0=200), start -> no fb_we, busy stays 0, CLIP=1, COUNT=0.
REQ-034: Full-screen fill (ORIGIN=0, SIZE=0xBFFF) -> 49152 writes ending at address 0xBFFF; a start written at cycle 100 -> OVR=1 and the fill is unaffected; COLOR written mid-fill is ignored.
REQ-035: Abort after 10 writes -> fb_we=0 from the next cycle, COUNT=10, busy=0; a subsequent start runs normally.
REQ-036: resetn=0 for one cycle mid-fill -> all outputs and STATUS read 0; no further writes occur.
